// File: rtl/step_dir_generator_pkg.sv
// Shared motion-control types and helpers.
// Phase encoding, direction polarity and timing clamp.
package rapcores_motion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIR_SETUP,
    STEP_HIGH,
    STEP_LOW,
    FINISH
  } state_t;

  localparam logic DIR_POSITIVE = 1'b1;
  localparam int CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp1(
    input logic [CLAMP_W-1:0] x
  );
    return (x == '0) ? CLAMP_W'(1) : x;
  endfunction

endpackage

// File: rtl/step_dir_generator_pulse_timer.sv
// Loadable down-counter timing one step/dir phase.
// expired is high in the last cycle of a loaded span.
module pulse_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count < W'(2));

endmodule

// File: rtl/step_dir_generator.sv
// Step/dir pulse train generator with dir setup,
// step high/low timing, abort and signed position.
module step_dir_generator
  import rapcores_motion_pkg::*;
#(
  parameter int COUNT_W  = 16,
  parameter int POS_W    = 32,
  parameter int TIMING_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [COUNT_W-1:0]        cmd_steps,
  input  logic                      cmd_dir,
  input  logic [COUNT_W-1:0]        cmd_interval,
  input  logic                      abort,
  input  logic [TIMING_W-1:0]       config_dir_setup,
  input  logic [TIMING_W-1:0]       config_step_high,
  output logic                      step,
  output logic                      dir,
  output logic                      busy,
  output logic                      done,
  output logic signed [POS_W-1:0]   position,
  output logic [COUNT_W-1:0]        steps_remaining
);

  localparam int T_W = (COUNT_W > TIMING_W) ? COUNT_W : TIMING_W;
  localparam logic signed [POS_W-1:0] ONE = 1;

  state_t state, next_state;
  logic   tmr_load, tmr_expired, abort_q, accept, enter_high;
  logic [T_W-1:0]     tmr_value, h_val, s_val;
  logic [COUNT_W-1:0] interval_q, rem_src;

  assign h_val = T_W'(clamp1(CLAMP_W'(config_step_high)));
  assign s_val = T_W'(clamp1(CLAMP_W'(config_dir_setup)));

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = (state == IDLE) && cmd_valid;
  assign enter_high = (next_state == STEP_HIGH) && (state != STEP_HIGH);
  assign rem_src    = accept ? cmd_steps : steps_remaining;

  pulse_timer #(.W(T_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            next_state = FINISH;
          end else if (cmd_dir != dir) begin
            next_state = DIR_SETUP;
            tmr_load   = 1'b1;
            tmr_value  = s_val;
          end else begin
            next_state = STEP_HIGH;
            tmr_load   = 1'b1;
            tmr_value  = h_val;
          end
        end
      end
      DIR_SETUP: begin
        if (abort) begin
          next_state = FINISH;
        end else if (tmr_expired) begin
          next_state = STEP_HIGH;
          tmr_load   = 1'b1;
          tmr_value  = h_val;
        end
      end
      STEP_HIGH: begin
        if (tmr_expired) begin
          if (abort || abort_q) begin
            next_state = FINISH;
          end else begin
            next_state = STEP_LOW;
            tmr_load   = 1'b1;
            tmr_value  = T_W'(interval_q);
          end
        end
      end
      STEP_LOW: begin
        // Expiry on the final step wins over abort: one done.
        if (tmr_expired) begin
          if (steps_remaining != '0 && !abort) begin
            next_state = STEP_HIGH;
            tmr_load   = 1'b1;
            tmr_value  = h_val;
          end else begin
            next_state = FINISH;
          end
        end else if (abort) begin
          next_state = FINISH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FINISH is never held: done pulses while the block is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      step            <= 1'b0;
      dir             <= 1'b0;
      done            <= 1'b0;
      abort_q         <= 1'b0;
      interval_q      <= '0;
      position        <= '0;
      steps_remaining <= '0;
    end else begin
      state   <= (next_state == FINISH) ? IDLE : next_state;
      done    <= (next_state == FINISH);
      step    <= (next_state == STEP_HIGH);
      abort_q <= (state == STEP_HIGH) &&
                 (next_state == STEP_HIGH) && (abort || abort_q);
      if (accept) begin
        dir        <= cmd_dir;
        interval_q <= COUNT_W'(clamp1(CLAMP_W'(cmd_interval)));
      end
      if (next_state == FINISH) begin
        steps_remaining <= '0;
      end else if (enter_high) begin
        steps_remaining <= (rem_src != '0) ?
                           rem_src - COUNT_W'(1) : '0;
      end else if (accept) begin
        steps_remaining <= cmd_steps;
      end
      if (enter_high) begin
        position <= (dir == DIR_POSITIVE) ?
                    position + ONE : position - ONE;
      end
    end
  end

endmodule

// File: tb/tb_step_dir_generator.sv
// Self-checking bench for step_dir_generator.
// Expected waveforms come from phase arithmetic on cycle numbers.
module tb_step_dir_generator;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic [15:0] cmd_interval;
  logic        abort;
  logic [7:0]  config_dir_setup;
  logic [7:0]  config_step_high;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic signed [31:0] position;
  logic [15:0] steps_remaining;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_pos = '0;
  logic        model_dir = 1'b0;

  step_dir_generator dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_steps        (cmd_steps),
    .cmd_dir          (cmd_dir),
    .cmd_interval     (cmd_interval),
    .abort            (abort),
    .config_dir_setup (config_dir_setup),
    .config_step_high (config_step_high),
    .step             (step),
    .dir              (dir),
    .busy             (busy),
    .done             (done),
    .position         (position),
    .steps_remaining  (steps_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a negedge; returns just after the done-cycle negedge.
  // ac = cycle (1 = first after accept) during which abort is held; -1 none.
  task automatic run_cmd(input int n_steps, input bit d, input int iv,
                         input int su, input int hi, input int ac,
                         input string tag);
    int h, s, l, per, first, done_at, issued, k, r, ph;
    bit chg, exp_step;
    logic [31:0] exp_pos;
    h = (hi < 1) ? 1 : hi;
    s = (su < 1) ? 1 : su;
    l = (iv < 1) ? 1 : iv;
    per = h + l;
    chg = (n_steps != 0) && (d != model_dir);
    first = chg ? 1 + s : 1;
    if (n_steps == 0) begin
      done_at = 1;
      issued = 0;
    end else begin
      done_at = first + n_steps * per;
      issued = n_steps;
      if (ac >= 1 && ac < done_at) begin
        if (ac < first) begin
          done_at = ac + 1;
          issued = 0;
        end else begin
          k = (ac - first) / per;
          r = (ac - first) % per;
          issued = k + 1;
          done_at = (r < h) ? first + k * per + h : ac + 1;
        end
      end
    end
    exp_pos = d ? model_pos + 32'(issued) : model_pos - 32'(issued);

    cmd_valid = 1'b1;
    cmd_steps = 16'(n_steps);
    cmd_dir = d;
    cmd_interval = 16'(iv);
    config_dir_setup = 8'(su);
    config_step_high = 8'(hi);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, cmd_ready);
    end
    @(posedge clk);
    for (int n = 1; n <= done_at; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      exp_step = 1'b0;
      ph = 0;
      if (n >= first && n < done_at) begin
        ph = (n - first) % per;
        exp_step = (ph < h) && ((n - first) / per < issued);
      end
      vectors++;
      if (step !== exp_step) begin
        miscompares++;
        $display("FAIL %s step@%0d: got %b want %b", tag, n, step, exp_step);
      end
      vectors++;
      if (dir !== d) begin
        miscompares++;
        $display("FAIL %s dir@%0d: got %b want %b", tag, n, dir, d);
      end
      vectors++;
      if (done !== (n == done_at)) begin
        miscompares++;
        $display("FAIL %s done@%0d: got %b want %b", tag, n, done,
                 n == done_at);
      end
      if (exp_step && ph == 0) begin
        vectors++;
        if (steps_remaining !== 16'(n_steps - ((n - first) / per + 1))) begin
          miscompares++;
          $display("FAIL %s remaining@%0d: got %0d want %0d", tag, n,
                   steps_remaining, n_steps - ((n - first) / per + 1));
        end
      end
      if (n == done_at) begin
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s ready_busy_at_done: got %b%b want 10", tag,
                   cmd_ready, busy);
        end
        vectors++;
        if (position !== exp_pos) begin
          miscompares++;
          $display("FAIL %s position: got %h want %h", tag, position,
                   exp_pos);
        end
        vectors++;
        if (steps_remaining !== 16'd0) begin
          miscompares++;
          $display("FAIL %s remaining_at_done: got %0d want 0", tag,
                   steps_remaining);
        end
      end else begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy@%0d: got %b want 1", tag, n, busy);
        end
      end
      abort = (n == ac) && (n < done_at);
    end
    abort = 1'b0;
    model_pos = exp_pos;
    model_dir = d;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({step, dir, busy, done, cmd_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00001",
               {step, dir, busy, done, cmd_ready});
    end
    vectors++;
    if (position !== 32'sd0 || steps_remaining !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got %h/%0d want 0/0", position,
               steps_remaining);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_cmd(3, 1'b0, 3, 1, 2, -1, "basic");
  endtask

  task automatic test_dir_setup();
    run_cmd(1, 1'b1, 1, 4, 1, -1, "dir_setup");
  endtask

  task automatic test_zero_steps();
    run_cmd(0, model_dir, 2, 2, 2, -1, "zero_steps");
  endtask

  task automatic test_abort_high();
    bit d;
    int first;
    d = 1'($urandom);
    first = (d != model_dir) ? 3 : 1;
    run_cmd(100, d, 10, 2, 3, first + 4 * 13 + 1, "abort_high");
  endtask

  task automatic test_abort_setup_low();
    run_cmd(4, ~model_dir, 2, 5, 2, 3, "abort_setup");
    run_cmd(4, model_dir, 5, 1, 2, 1 + 2 * 7 + 3, "abort_low");
    run_cmd(2, model_dir, 3, 1, 1, 1 + 2 * 4 - 1, "abort_final_low");
  endtask

  task automatic test_min_timing();
    run_cmd(4, ~model_dir, 0, 0, 0, -1, "min_timing");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      run_cmd($urandom_range(0, 5), 1'($urandom), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 3),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : -1,
              "random");
    end
  endtask

  task automatic test_wrap();
    force dut.position = 32'sh7FFF_FFFF;
    @(negedge clk);
    release dut.position;
    model_pos = 32'h7FFF_FFFF;
    run_cmd(1, 1'b1, 1, 1, 1, -1, "wrap");
  endtask

  task automatic test_reset_mid_pulse();
    cmd_valid = 1'b1;
    cmd_steps = 16'd5;
    cmd_dir = model_dir;
    cmd_interval = 16'd3;
    config_step_high = 8'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (step !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_prestep: got %b want 1", step);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({step, busy, done, cmd_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_reset_flags: got %b want 0001",
               {step, busy, done, cmd_ready});
    end
    vectors++;
    if (position !== 32'sd0 || steps_remaining !== 16'd0 || dir !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_state: got %h/%0d/%b want 0/0/0", position,
               steps_remaining, dir);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || step !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done: got %b%b want 00", done, step);
    end
    model_pos = '0;
    model_dir = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir = 1'b0;
    cmd_interval = '0;
    abort = 1'b0;
    config_dir_setup = '0;
    config_step_high = '0;
    test_reset();
    test_basic();
    test_dir_setup();
    test_zero_steps();
    test_abort_high();
    test_abort_setup_low();
    test_min_timing();
    test_back_to_back();
    test_wrap();
    test_reset_mid_pulse();
    test_basic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
